// File: rtl/subtrator_serial.sv
// Bit-serial N-bit subtractor: S = A - B - CIN, one bit per clock, LSB first.
// Ports:
//   CLK, RST_N       clock (rising edge), asynchronous active-low reset
//   START            request, accepted only while idle
//   A, B, CIN        minuend, subtrahend, borrow-in (captured on accepted START)
//   S, COUT          registered difference and final borrow-out
//   ZERO, OVF        registered zero flag and signed overflow
//   BUSY, DONE       operation in progress / one-cycle completion pulse
module subtrator_serial #(
    parameter int unsigned N = 8
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         START,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         CIN,
    output logic [N-1:0] S,
    output logic         COUT,
    output logic         ZERO,
    output logic         OVF,
    output logic         BUSY,
    output logic         DONE
);

    localparam int unsigned CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t        state_q;
    logic [N-1:0]  a_q;
    logic [N-1:0]  b_q;
    logic [N-1:0]  r_q;
    logic          br_q;
    logic [CW-1:0] cnt_q;

    logic          diff_d;
    logic          br_d;
    logic [N-1:0]  res_d;

    // Full-subtractor cell on the current LSBs; new bit enters the result at the MSB.
    always_comb begin
        diff_d = a_q[0] ^ b_q[0] ^ br_q;
        br_d   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
        res_d  = {diff_d, r_q[N-1:1]};
    end

    // Control FSM and datapath registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            S       <= '0;
            COUT    <= 1'b0;
            ZERO    <= 1'b0;
            OVF     <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            DONE <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (START) begin
                        a_q     <= A;
                        b_q     <= B;
                        br_q    <= CIN;
                        cnt_q   <= '0;
                        BUSY    <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    r_q   <= res_d;
                    br_q  <= br_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        // While the MSB is processed, br_q is the borrow into bit N-1.
                        S       <= res_d;
                        COUT    <= br_d;
                        ZERO    <= (res_d == '0);
                        OVF     <= br_q ^ br_d;
                        BUSY    <= 1'b0;
                        DONE    <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_subtrator_serial.sv
`timescale 1ns/1ps
module tb_subtrator_serial;

    logic       clk;
    logic       rst_n;

    logic       start8, cin8;
    logic [7:0] a8, b8, s8;
    logic       cout8, zero8, ovf8, busy8, done8;

    logic       start2, cin2;
    logic [1:0] a2, b2, s2;
    logic       cout2, zero2, ovf2, busy2, done2;

    int vec_cnt;
    int miss_cnt;

    subtrator_serial #(.N(8)) dut8 (
        .CLK(clk), .RST_N(rst_n), .START(start8), .A(a8), .B(b8), .CIN(cin8),
        .S(s8), .COUT(cout8), .ZERO(zero8), .OVF(ovf8), .BUSY(busy8), .DONE(done8)
    );

    subtrator_serial #(.N(2)) dut2 (
        .CLK(clk), .RST_N(rst_n), .START(start2), .A(a2), .B(b2), .CIN(cin2),
        .S(s2), .COUT(cout2), .ZERO(zero2), .OVF(ovf2), .BUSY(busy2), .DONE(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One 8-bit operation: BUSY/DONE timing, S held during CALC, final results.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic [7:0] es, input logic ec, input logic ez,
                       input logic eo, input string nm);
        logic [7:0] prev_s;
        @(negedge clk);
        prev_s = s8;
        a8 = a; b8 = b; cin8 = cin; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        // Operand changes after capture must not matter.
        a8 = ~a; b8 = ~b; cin8 = ~cin;
        for (int j = 0; j < 8; j++) begin
            vec_cnt++;
            if (busy8 !== 1'b1 || done8 !== 1'b0 || s8 !== prev_s) begin
                miss_cnt++;
                $display("FAIL %s calc cycle %0d: busy=%b done=%b s=%h want busy=1 done=0 s=%h",
                         nm, j, busy8, done8, s8, prev_s);
            end
            @(negedge clk);
        end
        vec_cnt++;
        if (done8 !== 1'b1 || busy8 !== 1'b0 || s8 !== es || cout8 !== ec ||
            zero8 !== ez || ovf8 !== eo) begin
            miss_cnt++;
            $display("FAIL %s result: done=%b busy=%b s=%h c=%b z=%b o=%b want done=1 busy=0 s=%h c=%b z=%b o=%b",
                     nm, done8, busy8, s8, cout8, zero8, ovf8, es, ec, ez, eo);
        end
        @(negedge clk);
        vec_cnt++;
        if (done8 !== 1'b0 || s8 !== es) begin
            miss_cnt++;
            $display("FAIL %s done_drop: done=%b s=%h want done=0 s=%h", nm, done8, s8, es);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if ({s8, cout8, zero8, ovf8, busy8, done8} !== 13'd0 ||
            {s2, cout2, zero2, ovf2, busy2, done2} !== 7'd0) begin
            miss_cnt++;
            $display("FAIL reset: n8=%h n2=%h want 0", {s8, cout8, zero8, ovf8, busy8, done8},
                     {s2, cout2, zero2, ovf2, busy2, done2});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        op8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, "5-3");
    endtask

    task automatic test_borrow_ovf();
        op8(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0, "3-5");
        op8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1, "80-1");
        op8(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1, "7f-ff");
    endtask

    task automatic test_cin_zero();
        op8(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, "10-0f-1");
        op8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, "0-0-1");
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        a8 = 8'h20; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);                 // j=0
        start8 = 1'b0;
        repeat (2) @(negedge clk);      // j=2
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);                 // j=3
        start8 = 1'b0;
        repeat (5) @(negedge clk);      // j=8
        vec_cnt++;
        if (done8 !== 1'b1 || s8 !== 8'h1F || cout8 !== 1'b0 || ovf8 !== 1'b0) begin
            miss_cnt++;
            $display("FAIL busy_start_ignored: done=%b s=%h c=%b o=%b want done=1 s=1f c=0 o=0",
                     done8, s8, cout8, ovf8);
        end
        a8 = 8'h09; b8 = 8'h04; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);                 // new j=0
        start8 = 1'b0;
        vec_cnt++;
        if (done8 !== 1'b0 || busy8 !== 1'b1 || s8 !== 8'h1F) begin
            miss_cnt++;
            $display("FAIL b2b_accept: done=%b busy=%b s=%h want done=0 busy=1 s=1f",
                     done8, busy8, s8);
        end
        repeat (7) @(negedge clk);      // j=7
        vec_cnt++;
        if (done8 !== 1'b0 || busy8 !== 1'b1) begin
            miss_cnt++;
            $display("FAIL b2b_early: done=%b busy=%b want done=0 busy=1", done8, busy8);
        end
        @(negedge clk);                 // j=8
        vec_cnt++;
        if (done8 !== 1'b1 || busy8 !== 1'b0 || s8 !== 8'h05 || cout8 !== 1'b0) begin
            miss_cnt++;
            $display("FAIL b2b_result: done=%b busy=%b s=%h c=%b want done=1 busy=0 s=05 c=0",
                     done8, busy8, s8, cout8);
        end
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        a8 = 8'h55; b8 = 8'h11; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);                 // j=0
        start8 = 1'b0;
        repeat (3) @(negedge clk);      // j=3
        #2 rst_n = 1'b0;
        #1;
        vec_cnt++;
        if ({s8, cout8, zero8, ovf8, busy8, done8} !== 13'd0) begin
            miss_cnt++;
            $display("FAIL reset_abort: outs=%h want 0", {s8, cout8, zero8, ovf8, busy8, done8});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            vec_cnt++;
            if (done8 !== 1'b0 || busy8 !== 1'b0 || s8 !== 8'h00) begin
                miss_cnt++;
                $display("FAIL post_abort cycle %0d: done=%b busy=%b s=%h want 0 0 00",
                         j, done8, busy8, s8);
            end
        end
        op8(8'h55, 8'h11, 1'b0, 8'h44, 1'b0, 1'b0, 1'b0, "55-11 after reset");
    endtask

    task automatic test_n2_sweep();
        int diff, sa, sb, sd;
        logic [1:0] es;
        logic ec, eo, ez;
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                for (int c = 0; c < 2; c++) begin
                    diff = a - b - c;
                    es   = 2'(diff & 3);
                    ec   = (diff < 0);
                    ez   = (es == 2'd0);
                    sa   = (a >= 2) ? a - 4 : a;
                    sb   = (b >= 2) ? b - 4 : b;
                    sd   = sa - sb - c;
                    eo   = (sd < -2) || (sd > 1);
                    @(negedge clk);
                    a2 = 2'(a); b2 = 2'(b); cin2 = 1'(c); start2 = 1'b1;
                    @(negedge clk);     // j=0
                    start2 = 1'b0;
                    @(negedge clk);     // j=1
                    vec_cnt++;
                    if (done2 !== 1'b0 || busy2 !== 1'b1) begin
                        miss_cnt++;
                        $display("FAIL n2 %0d-%0d-%0d early: done=%b busy=%b want 0 1",
                                 a, b, c, done2, busy2);
                    end
                    @(negedge clk);     // j=2
                    vec_cnt++;
                    if (done2 !== 1'b1 || busy2 !== 1'b0 || s2 !== es || cout2 !== ec ||
                        ovf2 !== eo || zero2 !== ez) begin
                        miss_cnt++;
                        $display("FAIL n2 %0d-%0d-%0d: done=%b s=%0d c=%b o=%b z=%b want done=1 s=%0d c=%b o=%b z=%b",
                                 a, b, c, done2, s2, cout2, ovf2, zero2, es, ec, eo, ez);
                    end
                end
            end
        end
    endtask

    initial begin
        vec_cnt  = 0;
        miss_cnt = 0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
        test_reset();
        test_basic();
        test_borrow_ovf();
        test_cin_zero();
        test_back_to_back();
        test_reset_abort();
        test_n2_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/subtrator_serial.md
Name: subtrator_serial

Overview:
- Parametrised bit-serial N-bit subtractor. Computes S = A - B - CIN over N clock cycles, one full-subtractor bit per cycle, LSB first.
- A single internal borrow flip-flop links the bits.
- START/BUSY/DONE handshake; reports final borrow, zero flag and signed overflow.
- Wide subtraction in the ALU datapath, where area matters more than latency.

Parameters:
N, 8, operand/result width in bits (N >= 2).

Ports:
CLK  input  1  clock, rising edge.
RST_N  input  1  reset, asynchronous, active-low.
START  input  1  request; sampled on rising CLK edge, only accepted while idle.
A  input  N  minuend, captured on accepted START.
B  input  N  subtrahend, captured on accepted START.
CIN  input  1  borrow-in, captured on accepted START.
S  output  N  difference, registered.
COUT  output  1  final borrow-out, registered.
ZERO  output  1  1 when S == 0, registered.
OVF  output  1  signed (two's complement) overflow, registered.
BUSY  output  1  1 while an operation is in progress.
DONE  output  1  one-cycle pulse when S/COUT/ZERO/OVF are updated.

Behaviour:
- Reset (RST_N=0, asynchronous, no clock needed):
  - State IDLE.
  - S=0, COUT=0, ZERO=0, OVF=0, BUSY=0, DONE=0.
  - Internal shift registers, borrow and counter cleared.
- States: IDLE, CALC.
- IDLE:
  - START=1 at an edge: latch A, B into internal shift registers; borrow <= CIN; counter <= 0; BUSY <= 1; state <= CALC.
  - START=0: remain in IDLE.
- CALC, each edge, with a0/b0 = current LSBs of the operand registers and br = borrow:
  - d = a0 ^ b0 ^ br.
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
  - d shifts into the MSB of the internal result register; operand registers shift right by 1; borrow <= br_next; counter++.
  - Borrow entering bit N-1 is saved to compute OVF.
- Last bit (counter == N-1) processed:
  - Same edge: S <= full result, COUT <= br_next, ZERO <= (result == 0), OVF <= saved borrow into MSB XOR br_next.
  - Same edge: BUSY <= 0, DONE <= 1, state <= IDLE.
- DONE:
  - High for exactly one cycle; cleared on the following edge unless another completion occurs.
- Latency:
  - START accepted at edge t0 gives DONE=1 between edges t0+N and t0+N+1.
  - BUSY is high from edge t0 to edge t0+N.
  - Throughput: one operation per N cycles.
- Output stability:
  - S/COUT/ZERO/OVF change only at completion.
  - They hold their previous values during CALC and idle.
  - Intermediate bits are never visible on S.
- START while BUSY: ignored; operands and CIN are not re-latched and the operation is unaffected.
- START in the cycle DONE is high: the state is IDLE, so START is accepted. This gives back-to-back operation and DONE drops on that edge.
- A/B/CIN changes after capture have no effect on the running operation.
- Reset mid-operation: immediate abort; all outputs return to reset values; no DONE pulse. The next START behaves normally.
- Arithmetic:
  - Result is modulo 2^N.
  - COUT=1 iff unsigned A < B + CIN.
  - OVF=1 iff the signed A - B - CIN lies outside [-2^(N-1), 2^(N-1)-1].

Test Plan:
1. N=8, A=0x05, B=0x03, CIN=0, START pulse at edge t0 -> DONE high only in the cycle after edge t0+8; S=0x02, COUT=0, ZERO=0, OVF=0; BUSY high exactly 8 cycles.
2. A=0x03, B=0x05, CIN=0 -> S=0xFE, COUT=1, ZERO=0, OVF=0. Then A=0x80, B=0x01, CIN=0 -> S=0x7F, COUT=0, OVF=1.
3. A=0x10, B=0x0F, CIN=1 -> S=0x00, ZERO=1, COUT=0, OVF=0. Then A=0x00, B=0x00, CIN=1 -> S=0xFF, COUT=1, ZERO=0.
4. Start A=0x20, B=0x01; pulse START with A=0xFF, B=0xFF at cycle 3 of CALC -> second START ignored; result S=0x1F at t0+8. A new START asserted during the DONE cycle (A=0x09, B=0x04) -> accepted; S=0x05 with DONE 8 cycles later.
5. Start A=0x55, B=0x11; drive RST_N low between edges at cycle 4 -> S, COUT, ZERO, OVF, BUSY, DONE all 0 immediately; no DONE ever appears. Release reset, START A=0x55, B=0x11 -> S=0x44 after 8 cycles.
6. N=2 instance, all 32 combinations of A, B, CIN (mirroring the 1-bit truth-table sweep) -> S, COUT, OVF match the reference model A-B-CIN mod 4 with its borrow and signed-overflow rules. DONE exactly 2 cycles after each START.
